// File: rtl/dice_result_tracker.sv
// Result tracker for the electronic dice: detects button release, latches the final face,
// offers it on a valid/ready handshake and keeps saturating per-face and total tallies.
module dice_result_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic [2:0]       throw,
    output logic [2:0]       result,
    output logic             result_valid,
    input  logic             result_ready,
    input  logic [2:0]       face_sel,
    output logic [CNT_W-1:0] face_count,
    output logic [CNT_W-1:0] total_count,
    output logic             error,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        DONE,
        DONE_ROLL
    } state_t;

    state_t           state_q, state_d;
    logic             btn_q;
    logic [2:0]       result_q, result_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] tally_q [6];
    logic [CNT_W-1:0] tally_d [6];
    logic             error_q, error_d;
    logic             overrun_q, overrun_d;

    logic release_evt;
    logic handshake;
    logic face_ok;
    logic capture;

    assign release_evt = btn_q & ~button;
    assign handshake   = valid_q & result_ready;
    assign face_ok     = (throw >= 3'd1) && (throw <= 3'd6);

    // NOTE: every always_comb output starts from a default so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        valid_d   = valid_q;
        total_d   = total_q;
        tally_d   = tally_q;
        error_d   = error_q;
        overrun_d = overrun_q;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (button) state_d = ROLL;
            end
            ROLL: begin
                if (release_evt) begin
                    if (face_ok) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = button ? ROLL : IDLE;
                end else if (button) begin
                    state_d = DONE_ROLL;
                end
            end
            DONE_ROLL: begin
                if (release_evt) begin
                    if (face_ok) begin
                        capture = 1'b1;
                        if (!handshake) overrun_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        // An accept on the same edge still consumes the old face.
                        if (handshake) begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else if (handshake) begin
                    valid_d = 1'b0;
                    state_d = ROLL;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            result_d = throw;
            valid_d  = 1'b1;
            if (total_q != '1) total_d = total_q + CNT_W'(1);
            for (int i = 0; i < 6; i++) begin
                if (throw == 3'(i + 1) && tally_q[i] != '1) tally_d[i] = tally_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments only in sequential logic; the tally array is reset
    // explicitly because its contents are architecturally visible counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            btn_q     <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            total_q   <= '0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 6; i++) tally_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            btn_q     <= button;
            result_q  <= result_d;
            valid_q   <= valid_d;
            total_q   <= total_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
            tally_q   <= tally_d;
        end
    end

    always_comb begin
        face_count = '0;
        for (int i = 0; i < 6; i++) begin
            if (face_sel == 3'(i + 1)) face_count = tally_q[i];
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign total_count  = total_q;
    assign error        = error_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dice_result_tracker.sv
// Directed, table-driven bench for dice_result_tracker, plus hand sequences for
// asynchronous reset and counter saturation (second instance with CNT_W=2).
module tb_dice_result_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button, result_ready;
    logic [2:0] throw, face_sel;
    logic [2:0] result;
    logic       result_valid, error, overrun;
    logic [7:0] face_count, total_count;

    logic       b2, rdy2;
    logic [2:0] thr2, sel2, res2;
    logic       val2, err2, ovr2;
    logic [1:0] fc2, tot2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dice_result_tracker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .throw(throw),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .face_sel(face_sel), .face_count(face_count), .total_count(total_count),
        .error(error), .overrun(overrun)
    );

    dice_result_tracker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .button(b2), .throw(thr2),
        .result(res2), .result_valid(val2), .result_ready(rdy2),
        .face_sel(sel2), .face_count(fc2), .total_count(tot2),
        .error(err2), .overrun(ovr2)
    );

    typedef struct {
        logic       btn;
        logic [2:0] thr;
        logic       rdy;
        logic [2:0] sel;
        logic [2:0] e_res;
        logic       e_val;
        logic [7:0] e_tot;
        logic [7:0] e_fc;
        logic       e_err;
        logic       e_ovr;
    } vec_t;

    vec_t vecs [37];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " result"}, 32'(result), 0);
        check({tag, " valid"}, 32'(result_valid), 0);
        check({tag, " total"}, 32'(total_count), 0);
        check({tag, " face_count"}, 32'(face_count), 0);
        check({tag, " error"}, 32'(error), 0);
        check({tag, " overrun"}, 32'(overrun), 0);
    endtask

    function automatic vec_t mk(logic btn, logic [2:0] thr, logic rdy, logic [2:0] sel,
                                logic [2:0] r, logic v, logic [7:0] t, logic [7:0] f,
                                logic e, logic o);
        vec_t x;
        x.btn = btn; x.thr = thr; x.rdy = rdy; x.sel = sel;
        x.e_res = r; x.e_val = v; x.e_tot = t; x.e_fc = f; x.e_err = e; x.e_ovr = o;
        return x;
    endfunction

    initial begin
        // Long press with throw stepping 1..6,1,2; release at 2.
        vecs[0]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 3, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 4, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 5, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 6, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 2, 0, 2, 2, 1, 1, 1, 0, 0);
        // Held unconsumed for 5 cycles, then accepted.
        vecs[9]  = mk(0, 2, 0, 2, 2, 1, 1, 1, 0, 0);
        vecs[10] = mk(0, 2, 0, 2, 2, 1, 1, 1, 0, 0);
        vecs[11] = mk(0, 2, 0, 2, 2, 1, 1, 1, 0, 0);
        vecs[12] = mk(0, 2, 0, 2, 2, 1, 1, 1, 0, 0);
        vecs[13] = mk(0, 2, 0, 2, 2, 1, 1, 1, 0, 0);
        vecs[14] = mk(0, 2, 1, 2, 2, 0, 1, 1, 0, 0);
        // Roll to 4.
        vecs[15] = mk(1, 4, 0, 4, 2, 0, 1, 0, 0, 0);
        vecs[16] = mk(1, 4, 0, 4, 2, 0, 1, 0, 0, 0);
        vecs[17] = mk(0, 4, 0, 4, 4, 1, 2, 1, 0, 0);
        // Re-roll released on the accepting edge: no overrun.
        vecs[18] = mk(1, 5, 0, 3, 4, 1, 2, 0, 0, 0);
        vecs[19] = mk(0, 3, 1, 3, 3, 1, 3, 1, 0, 0);
        // Re-roll with nothing accepted: overrun.
        vecs[20] = mk(1, 1, 0, 6, 3, 1, 3, 0, 0, 0);
        vecs[21] = mk(1, 6, 0, 6, 3, 1, 3, 0, 0, 0);
        vecs[22] = mk(0, 6, 0, 6, 6, 1, 4, 1, 0, 1);
        vecs[23] = mk(0, 6, 0, 4, 6, 1, 4, 1, 0, 1);
        vecs[24] = mk(0, 6, 1, 3, 6, 0, 4, 1, 0, 1);
        // Invalid face 0 from ROLL.
        vecs[25] = mk(1, 0, 0, 6, 6, 0, 4, 1, 0, 1);
        vecs[26] = mk(0, 0, 0, 6, 6, 0, 4, 1, 1, 1);
        // Roll to 5, then invalid 7 during a re-roll keeps the old result.
        vecs[27] = mk(1, 5, 0, 5, 6, 0, 4, 0, 1, 1);
        vecs[28] = mk(0, 5, 0, 5, 5, 1, 5, 1, 1, 1);
        vecs[29] = mk(1, 7, 0, 0, 5, 1, 5, 0, 1, 1);
        vecs[30] = mk(0, 7, 0, 7, 5, 1, 5, 0, 1, 1);
        vecs[31] = mk(0, 7, 0, 2, 5, 1, 5, 1, 1, 1);
        // Accept in DONE while pressing goes straight to ROLL.
        vecs[32] = mk(1, 1, 1, 1, 5, 0, 5, 0, 1, 1);
        vecs[33] = mk(0, 1, 0, 1, 1, 1, 6, 1, 1, 1);
        // Accept in DONE_ROLL before release.
        vecs[34] = mk(1, 4, 0, 4, 1, 1, 6, 1, 1, 1);
        vecs[35] = mk(1, 4, 1, 4, 1, 0, 6, 1, 1, 1);
        vecs[36] = mk(0, 4, 0, 4, 4, 1, 7, 2, 1, 1);

        rst_n = 1'b0; button = 1'b0; throw = 3'd0; result_ready = 1'b0; face_sel = 3'd2;
        b2 = 1'b0; thr2 = 3'd0; rdy2 = 1'b1; sel2 = 3'd3;
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            button = vecs[i].btn; throw = vecs[i].thr;
            result_ready = vecs[i].rdy; face_sel = vecs[i].sel;
            @(posedge clk); #1;
            check($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].e_res));
            check($sformatf("v%0d valid", i), 32'(result_valid), 32'(vecs[i].e_val));
            check($sformatf("v%0d total", i), 32'(total_count), 32'(vecs[i].e_tot));
            check($sformatf("v%0d face_count", i), 32'(face_count), 32'(vecs[i].e_fc));
            check($sformatf("v%0d error", i), 32'(error), 32'(vecs[i].e_err));
            check($sformatf("v%0d overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
        end

        // Asynchronous reset while in DONE, button held through reset.
        @(negedge clk);
        result_ready = 1'b0; face_sel = 3'd4; button = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("rst_done");
        @(negedge clk);
        button = 1'b0; throw = 3'd3; rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_capture_after_reset valid", 32'(result_valid), 0);
        check("no_capture_after_reset total", 32'(total_count), 0);

        // Capture a 2, then reset in the middle of the next roll.
        @(negedge clk); button = 1'b1; throw = 3'd2; face_sel = 3'd2;
        @(negedge clk); button = 1'b0;
        @(posedge clk); #1;
        check("pre_midroll result", 32'(result), 2);
        check("pre_midroll valid", 32'(result_valid), 1);
        @(negedge clk); button = 1'b1;
        @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check_all_zero("rst_midroll");
        @(negedge clk); rst_n = 1'b1; button = 1'b0;

        // Saturation on a 2-bit instance: five captures of face 3.
        for (int n = 0; n < 5; n++) begin
            @(negedge clk); b2 = 1'b1; thr2 = 3'd3;
            @(negedge clk); b2 = 1'b0;
            @(posedge clk); #1;
            if (n == 1) check("sat two captures total", 32'(tot2), 2);
            @(negedge clk);
        end
        @(posedge clk); #1;
        check("sat tally3", 32'(fc2), 3);
        check("sat total", 32'(tot2), 3);
        check("sat result", 32'(res2), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
